// File: rtl/resize_job_scheduler_if.sv
// Job handshake between the resize scheduler and the cubic-engine control.
// With ROW_REUSE_EN defined the bundle also carries job_new_rows.
interface resize_job_scheduler_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              job_valid;
    logic              job_ready;
    logic [5:0]        job_th;
    logic [5:0]        job_tv;
    logic [6:0]        job_src_h;
    logic [6:0]        job_src_v;
    logic [5:0]        job_rem_h;
    logic [5:0]        job_rem_v;
    logic [ADDR_W-1:0] job_addr;
    logic              job_last;
`ifdef ROW_REUSE_EN
    logic [2:0]        job_new_rows;
`endif

    modport master (
        output job_valid, job_th, job_tv, job_src_h, job_src_v,
               job_rem_h, job_rem_v, job_addr, job_last,
`ifdef ROW_REUSE_EN
               job_new_rows,
`endif
        input  job_ready
    );

    modport slave (
        input  job_valid, job_th, job_tv, job_src_h, job_src_v,
               job_rem_h, job_rem_v, job_addr, job_last,
`ifdef ROW_REUSE_EN
               job_new_rows,
`endif
        output job_ready
    );
endinterface

// File: rtl/resize_job_scheduler.sv
// Walks the TW x TH target grid row-major and issues one resize job per pixel, using
// divider-free quotient/remainder accumulation. Optional macro: ROW_REUSE_EN (job_new_rows).
module resize_job_scheduler #(
    parameter int unsigned IMG_DIM = 100,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [6:0]             H0,
    input  logic [6:0]             V0,
    input  logic [4:0]             SW,
    input  logic [4:0]             SH,
    input  logic [5:0]             TW,
    input  logic [5:0]             TH,
    resize_job_scheduler_if.master job,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StCheck, StEmit, StStepH, StStepV, StDone
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        cfg_h0_q, cfg_h0_d, cfg_v0_q, cfg_v0_d;
    logic [4:0]        cfg_sw_q, cfg_sw_d, cfg_sh_q, cfg_sh_d;
    logic [5:0]        cfg_tw_q, cfg_tw_d, cfg_th_q, cfg_th_d;
    logic [5:0]        col_q, col_d, row_q, row_d;
    logic [4:0]        quot_h_q, quot_h_d, quot_v_q, quot_v_d;
    logic [6:0]        rem_h_q, rem_h_d, rem_v_q, rem_v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cfg_err_q, cfg_err_d;
`ifdef ROW_REUSE_EN
    logic [4:0]        prev_quot_v_q, prev_quot_v_d;
    logic              first_q, first_d;
    logic [4:0]        row_delta;
`endif

    logic [6:0] sw_m1, sh_m1, tw_m1, th_m1;
    logic [7:0] h_end, v_end;
    logic       last_col, last_row, cfg_bad;
    logic       h_carry, v_carry;
    logic [6:0] rem_h_red, rem_v_red;

    assign sw_m1 = 7'(cfg_sw_q) - 7'd1;
    assign sh_m1 = 7'(cfg_sh_q) - 7'd1;
    assign tw_m1 = 7'(cfg_tw_q) - 7'd1;
    assign th_m1 = 7'(cfg_th_q) - 7'd1;
    assign h_end = 8'(cfg_h0_q) + 8'(cfg_sw_q);
    assign v_end = 8'(cfg_v0_q) + 8'(cfg_sh_q);

    assign last_col = (col_q == cfg_tw_q - 6'd1);
    assign last_row = (row_q == cfg_th_q - 6'd1);
    assign cfg_bad  = (cfg_tw_q < 6'd2) || (cfg_th_q < 6'd2) || (cfg_sw_q < 5'd2) ||
                      (cfg_sh_q < 5'd2) || (h_end > 8'(IMG_DIM)) || (v_end > 8'(IMG_DIM));

    // One normalisation step: at most one subtraction of T-1 per cycle.
    assign h_carry   = (rem_h_q >= tw_m1);
    assign v_carry   = (rem_v_q >= th_m1);
    assign rem_h_red = h_carry ? rem_h_q - tw_m1 : rem_h_q;
    assign rem_v_red = v_carry ? rem_v_q - th_m1 : rem_v_q;

    always_comb begin
        state_d   = state_q;
        cfg_h0_d  = cfg_h0_q;
        cfg_v0_d  = cfg_v0_q;
        cfg_sw_d  = cfg_sw_q;
        cfg_sh_d  = cfg_sh_q;
        cfg_tw_d  = cfg_tw_q;
        cfg_th_d  = cfg_th_q;
        col_d     = col_q;
        row_d     = row_q;
        quot_h_d  = quot_h_q;
        quot_v_d  = quot_v_q;
        rem_h_d   = rem_h_q;
        rem_v_d   = rem_v_q;
        addr_d    = addr_q;
        cfg_err_d = cfg_err_q;
`ifdef ROW_REUSE_EN
        prev_quot_v_d = prev_quot_v_q;
        first_d       = first_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    cfg_err_d = 1'b0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                cfg_h0_d = H0;
                cfg_v0_d = V0;
                cfg_sw_d = SW;
                cfg_sh_d = SH;
                cfg_tw_d = TW;
                cfg_th_d = TH;
                col_d    = '0;
                row_d    = '0;
                quot_h_d = '0;
                quot_v_d = '0;
                rem_h_d  = '0;
                rem_v_d  = '0;
                addr_d   = '0;
`ifdef ROW_REUSE_EN
                prev_quot_v_d = '0;
                first_d       = 1'b1;
`endif
                state_d  = StCheck;
            end
            StCheck: begin
                if (cfg_bad) begin
                    cfg_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    state_d   = StEmit;
                end
            end
            StEmit: begin
                if (job.job_ready) begin
                    addr_d = addr_q + 1'b1;
`ifdef ROW_REUSE_EN
                    prev_quot_v_d = quot_v_q;
                    first_d       = 1'b0;
`endif
                    if (last_col && last_row) begin
                        state_d = StDone;
                    end else if (last_col) begin
                        col_d    = '0;
                        quot_h_d = '0;
                        rem_h_d  = '0;
                        row_d    = row_q + 6'd1;
                        rem_v_d  = rem_v_q + sh_m1;
                        state_d  = StStepV;
                    end else begin
                        col_d   = col_q + 6'd1;
                        rem_h_d = rem_h_q + sw_m1;
                        state_d = StStepH;
                    end
                end
            end
            StStepH: begin
                rem_h_d  = rem_h_red;
                quot_h_d = quot_h_q + 5'(h_carry);
                state_d  = (rem_h_red >= tw_m1) ? StStepH : StEmit;
            end
            StStepV: begin
                rem_v_d  = rem_v_red;
                quot_v_d = quot_v_q + 5'(v_carry);
                state_d  = (rem_v_red >= th_m1) ? StStepV : StEmit;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cfg_h0_q  <= '0;
            cfg_v0_q  <= '0;
            cfg_sw_q  <= '0;
            cfg_sh_q  <= '0;
            cfg_tw_q  <= '0;
            cfg_th_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            quot_h_q  <= '0;
            quot_v_q  <= '0;
            rem_h_q   <= '0;
            rem_v_q   <= '0;
            addr_q    <= '0;
            cfg_err_q <= 1'b0;
`ifdef ROW_REUSE_EN
            prev_quot_v_q <= '0;
            first_q       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cfg_h0_q  <= cfg_h0_d;
            cfg_v0_q  <= cfg_v0_d;
            cfg_sw_q  <= cfg_sw_d;
            cfg_sh_q  <= cfg_sh_d;
            cfg_tw_q  <= cfg_tw_d;
            cfg_th_q  <= cfg_th_d;
            col_q     <= col_d;
            row_q     <= row_d;
            quot_h_q  <= quot_h_d;
            quot_v_q  <= quot_v_d;
            rem_h_q   <= rem_h_d;
            rem_v_q   <= rem_v_d;
            addr_q    <= addr_d;
            cfg_err_q <= cfg_err_d;
`ifdef ROW_REUSE_EN
            prev_quot_v_q <= prev_quot_v_d;
            first_q       <= first_d;
`endif
        end
    end

`ifdef ROW_REUSE_EN
    // quot_v never decreases within a frame, so the difference is non-negative.
    assign row_delta = quot_v_q - prev_quot_v_q;
`endif

    always_comb begin
        job.job_valid = (state_q == StEmit);
        job.job_th    = col_q;
        job.job_tv    = row_q;
        job.job_src_h = cfg_h0_q + 7'(quot_h_q);
        job.job_src_v = cfg_v0_q + 7'(quot_v_q);
        job.job_rem_h = rem_h_q[5:0];
        job.job_rem_v = rem_v_q[5:0];
        job.job_addr  = addr_q;
        job.job_last  = last_col && last_row;
`ifdef ROW_REUSE_EN
        if (first_q) begin
            job.job_new_rows = 3'd4;
        end else if (row_delta > 5'd4) begin
            job.job_new_rows = 3'd4;
        end else begin
            job.job_new_rows = row_delta[2:0];
        end
`endif
        busy    = (state_q == StLoad) || (state_q == StCheck) || (state_q == StEmit) ||
                  (state_q == StStepH) || (state_q == StStepV);
        done    = (state_q == StDone);
        cfg_err = cfg_err_q;
    end

endmodule

// File: tb/tb_resize_job_scheduler.sv
// Scoreboard bench for resize_job_scheduler: an arithmetic reference model fills the
// expected-job queue, a negedge monitor pops and compares every transfer.
module tb_resize_job_scheduler;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic [6:0] H0 = '0, V0 = '0;
    logic [4:0] SW = '0, SH = '0;
    logic [5:0] TW = '0, TH = '0;
    logic       busy, done, cfg_err;

    resize_job_scheduler_if bif ();

    resize_job_scheduler dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .H0      (H0),
        .V0      (V0),
        .SW      (SW),
        .SH      (SH),
        .TW      (TW),
        .TH      (TH),
        .job     (bif),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int th, tv, src_h, src_v, rem_h, rem_v, addr, last, nr;
    } job_t;

    job_t exp_q[$];
    job_t last_seen;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_xfer   = 0;
    bit   rand_mode = 1'b0;

    task automatic check(input bit ok, input string name, input string act, input string req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, required %s", name, act, req);
    endtask

    function automatic string fmt(input job_t j);
        return $sformatf("th=%0d tv=%0d src=%0d/%0d rem=%0d/%0d addr=%0d last=%0d nr=%0d",
                         j.th, j.tv, j.src_h, j.src_v, j.rem_h, j.rem_v, j.addr, j.last, j.nr);
    endfunction

    function automatic bit same(input job_t a, input job_t b);
        return a.th == b.th && a.tv == b.tv && a.src_h == b.src_h && a.src_v == b.src_v &&
               a.rem_h == b.rem_h && a.rem_v == b.rem_v && a.addr == b.addr &&
               a.last == b.last && a.nr == b.nr;
    endfunction

    function automatic job_t sample();
        job_t j;
        j.th    = int'(bif.job_th);
        j.tv    = int'(bif.job_tv);
        j.src_h = int'(bif.job_src_h);
        j.src_v = int'(bif.job_src_v);
        j.rem_h = int'(bif.job_rem_h);
        j.rem_v = int'(bif.job_rem_v);
        j.addr  = int'(bif.job_addr);
        j.last  = int'(bif.job_last);
`ifdef ROW_REUSE_EN
        j.nr    = int'(bif.job_new_rows);
`else
        j.nr    = 0;
`endif
        return j;
    endfunction

    function automatic bit outputs_zero();
        bit z;
        z = ({bif.job_valid, bif.job_th, bif.job_tv, bif.job_src_h, bif.job_src_v,
              bif.job_rem_h, bif.job_rem_v, bif.job_addr, bif.job_last,
              busy, done, cfg_err} == '0);
`ifdef ROW_REUSE_EN
        z = z && (bif.job_new_rows == 3'd0);
`endif
        return z;
    endfunction

    function automatic bit cfg_ok(input int h0, v0, sw, sh, tw, th);
        return tw >= 2 && th >= 2 && sw >= 2 && sh >= 2 && h0 + sw <= 100 && v0 + sh <= 100;
    endfunction

    // Reference: each target pixel maps to base + floor(t*(S-1)/(T-1)) directly.
    task automatic push_frame(input int h0, v0, sw, sh, tw, th);
        int prev_qv;
        prev_qv = 0;
        for (int r = 0; r < th; r++) begin
            for (int c = 0; c < tw; c++) begin
                job_t j;
                int qv;
                qv      = (r * (sh - 1)) / (th - 1);
                j.th    = c;
                j.tv    = r;
                j.src_h = h0 + (c * (sw - 1)) / (tw - 1);
                j.src_v = v0 + qv;
                j.rem_h = (c * (sw - 1)) % (tw - 1);
                j.rem_v = (r * (sh - 1)) % (th - 1);
                j.addr  = r * tw + c;
                j.last  = (r == th - 1 && c == tw - 1) ? 1 : 0;
`ifdef ROW_REUSE_EN
                if (r == 0 && c == 0) j.nr = 4;
                else j.nr = (qv - prev_qv > 4) ? 4 : qv - prev_qv;
`else
                j.nr    = 0;
`endif
                prev_qv = qv;
                exp_q.push_back(j);
            end
        end
    endtask

    // Ready driver: always-ready or coin-flip backpressure.
    initial begin
        bif.job_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            bif.job_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops on every transfer and checks stall stability.
    initial begin
        bit   stalled;
        job_t held, cur;
        stalled = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                stalled = 1'b0;
            end else if (bif.job_valid) begin
                cur = sample();
                if (stalled)
                    check(same(cur, held), "stall_stable", fmt(cur), fmt(held));
                if (bif.job_ready) begin
                    n_xfer++;
                    last_seen = cur;
                    stalled   = 1'b0;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_job", fmt(cur), "no job");
                    end else begin
                        job_t e;
                        e = exp_q.pop_front();
                        check(same(cur, e), "job", fmt(cur), fmt(e));
                    end
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end else if (stalled) begin
                check(1'b0, "valid_dropped", "job_valid=0", "job_valid=1 while stalled");
                stalled = 1'b0;
            end
        end
    end

    task automatic start_frame(input int h0, v0, sw, sh, tw, th);
        bit ok;
        ok = cfg_ok(h0, v0, sw, sh, tw, th);
        if (ok) push_frame(h0, v0, sw, sh, tw, th);
        @(posedge CLK);
        #1;
        H0 = 7'(h0); V0 = 7'(v0); SW = 5'(sw); SH = 5'(sh); TW = 6'(tw); TH = 6'(th);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(negedge CLK);
        check(busy && !done && !cfg_err, "load_flags",
              $sformatf("busy=%0b done=%0b cfg_err=%0b", busy, done, cfg_err), "1/0/0");
        @(negedge CLK);
        check(!bif.job_valid, "no_valid_in_check", $sformatf("%0b", bif.job_valid), "0");
        @(negedge CLK);
        if (ok)
            check(bif.job_valid, "first_valid_latency", $sformatf("%0b", bif.job_valid), "1");
        else
            check(done && cfg_err && !bif.job_valid, "cfg_err_done",
                  $sformatf("done=%0b cfg_err=%0b valid=%0b", done, cfg_err, bif.job_valid),
                  "1/1/0");
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles && !done; i++) @(negedge CLK);
        check(done, "done_reached", $sformatf("done=%0b", done), "1");
        check(exp_q.size() == 0, "queue_drained", $sformatf("%0d left", exp_q.size()), "0 left");
    endtask

    task automatic run_frame(input int h0, v0, sw, sh, tw, th);
        start_frame(h0, v0, sw, sh, tw, th);
        wait_done(40000);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check(outputs_zero(), "reset_outputs", "nonzero output", "all 0");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reference upscale config, always ready.
        base = n_xfer;
        run_frame(81, 18, 17, 15, 22, 28);
        check(n_xfer - base == 616, "xfer_count", $sformatf("%0d", n_xfer - base), "616");
        check(last_seen.th == 21 && last_seen.tv == 27 && last_seen.src_h == 97 &&
              last_seen.src_v == 32 && last_seen.rem_h == 0 && last_seen.rem_v == 0 &&
              last_seen.addr == 615 && last_seen.last == 1,
              "final_job", fmt(last_seen), "th=21 tv=27 src=97/32 rem=0/0 addr=615 last=1");

        // Same config under random backpressure.
        rand_mode = 1'b1;
        run_frame(81, 18, 17, 15, 22, 28);

        // Downscale with multi-cycle STEP_H.
        run_frame(0, 0, 20, 2, 4, 2);

        // Rejected window, then a good start clears cfg_err.
        base = n_xfer;
        start_frame(90, 18, 17, 15, 22, 28);
        repeat (3) @(negedge CLK);
        check(n_xfer == base && done && cfg_err, "cfg_err_no_jobs",
              $sformatf("xfers=%0d done=%0b cfg_err=%0b", n_xfer - base, done, cfg_err),
              "0/1/1");
        run_frame(0, 0, 20, 2, 4, 2);
        check(!cfg_err, "cfg_err_cleared", $sformatf("%0b", cfg_err), "0");

        // Reset mid-frame at transfer 100.
        rand_mode = 1'b0;
        base = n_xfer;
        start_frame(81, 18, 17, 15, 22, 28);
        for (int i = 0; i < 2000 && n_xfer - base < 100; i++) @(negedge CLK);
        check(n_xfer - base >= 100, "reach_xfer_100", $sformatf("%0d", n_xfer - base), "100");
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check(outputs_zero(), "midframe_reset_outputs", "nonzero output", "all 0");
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check(!bif.job_valid && !busy, "idle_after_reset",
              $sformatf("valid=%0b busy=%0b", bif.job_valid, busy), "0/0");
        run_frame(81, 18, 17, 15, 22, 28);

        // Random legal configurations with backpressure.
        rand_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int sw, sh;
            sw = $urandom_range(2, 16);
            sh = $urandom_range(2, 16);
            run_frame($urandom_range(0, 100 - sw), $urandom_range(0, 100 - sh), sw, sh,
                      $urandom_range(2, 20), $urandom_range(2, 12));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/resize_job_scheduler.md
Name: resize_job_scheduler

Overview:
- Sequencer for the bicubic resize datapath. After `start`, it walks the TW×TH target grid in row-major order.
- For each target pixel it computes the source anchor and the fractional remainder along both axes, using incremental division: quotient/remainder accumulation, no divider.
- Each result is issued as a job to the cubic-engine control over a valid/ready handshake.
- It sits between the top-level configuration inputs and the ROM-fetch / cubic-engine / ResultSRAM-write pipeline.

Parameters:
- IMG_DIM, 100, source image side length in pixels (ROM is IMG_DIM×IMG_DIM).
- ADDR_W, 12, width of the result-SRAM linear address (covers 63×63).

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- start  in  1  one-cycle request to begin a resize; ignored unless in IDLE or DONE
- H0  in  7  source window left column
- V0  in  7  source window top row
- SW  in  5  source window width
- SH  in  5  source window height
- TW  in  6  target width
- TH  in  6  target height
- job_valid  out  1  job fields valid
- job_ready  in  1  downstream accepts the job
- job_th  out  6  target column
- job_tv  out  6  target row
- job_src_h  out  7  H0 + floor(th·(SW−1)/(TW−1))
- job_src_v  out  7  V0 + floor(tv·(SH−1)/(TH−1))
- job_rem_h  out  6  remainder of the h division, 0..TW−2
- job_rem_v  out  6  remainder of the v division, 0..TH−2
- job_addr  out  ADDR_W  tv·TW + th
- job_last  out  1  this is the final job of the frame
- busy  out  1  high from LOAD until DONE
- done  out  1  frame complete; level signal
- cfg_err  out  1  configuration rejected

Behaviour:
- Reset is RST, synchronous, active-high; clock is CLK.
- Reset values: all outputs 0; state IDLE; all counters and accumulators 0. RST mid-frame aborts to IDLE immediately, with no further jobs.
- States:
  - IDLE: wait for `start`.
  - LOAD: latch H0/V0/SW/SH/TW/TH into internal registers; clear th, tv, quotients and remainders.
  - CHECK: evaluate the configuration.
  - EMIT: present a job.
  - STEP_H: h-accumulator normalisation.
  - STEP_V: v-accumulator normalisation.
  - DONE.
- Sequence IDLE --start--> LOAD --> CHECK. `start` in DONE behaves as in IDLE and clears `done` and `cfg_err`.
- CHECK: if TW<2, TH<2, SW<2, SH<2, H0+SW>IMG_DIM or V0+SH>IMG_DIM, then `cfg_err`=1 and go to DONE with no job. Otherwise go to EMIT.
- Latency: first `job_valid` appears 3 cycles after the `start` cycle.
- EMIT: `job_valid`=1 and all job fields stable while `job_ready`=0. A transfer occurs on a cycle with `job_valid` & `job_ready`.
- After a transfer, not at end of row: th++, rem_h += SW−1, go to STEP_H.
- After a transfer, at end of row (th==TW−1, not last): th=0, quot_h=0, rem_h=0, tv++, rem_v += SH−1, go to STEP_V.
- STEP_H / STEP_V: each cycle, if rem ≥ T−1 then rem −= T−1 and quot++. Stay in the state while rem ≥ T−1, then return to EMIT. This handles downscale; upscale takes exactly 1 cycle. `job_valid`=0 during STEP states.
- Width rules: accumulator is 7 bits unsigned (rem+S−1 ≤ 91); quot ≤ 30; job_src = base + quot, which never overflows after CHECK.
- job_addr is maintained incrementally: +1 per transfer, no multiplier.
- job_last = (th==TW−1)&&(tv==TH−1). Transfer of the last job goes to DONE.
- DONE: `done`=1, `busy`=0; held until `start` or RST.

Optional Feature:
- Macro ROW_REUSE_EN.
- When defined: add output `job_new_rows` (3 bits) = number of new source rows versus the previous job's src_v, i.e. quot_v − prev_quot_v, saturated at 4. The first job of the frame reports 4. Within a row the value is 0 for all jobs except th==0. This lets the datapath shift its 4-line P buffer instead of refetching.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- H0=81 V0=18 SW=17 SH=15 TW=22 TH=28, job_ready=1:
  - job0: src_h 81, src_v 18, rem 0/0, addr 0.
  - th=1: src_h 81, rem_h 16.
  - th=2: src_h 82, rem_h 11.
  - Final job: th 21, tv 27, src_h 97, src_v 32, rem 0/0, addr 615, job_last=1.
  - Exactly 616 transfers, then `done`=1.
- Same config, job_ready toggled 0/1 pseudo-randomly → job fields stable while stalled; identical job sequence; no drops or duplicates.
- Downscale SW=20 TW=4 (SH=2 TH=2, H0=V0=0):
  - th=1 → src_h 6, rem_h 1.
  - th=2 → src_h 12, rem_h 2.
  - th=3 → src_h 19, rem_h 0.
  - job_valid low during multi-cycle STEP_H.
- H0=90 SW=17 → cfg_err=1, done=1 within 3 cycles, zero jobs. A following valid `start` clears `cfg_err` and runs normally.
- RST asserted at transfer 100 of the first config → all outputs 0 next cycle. A new `start` restarts from job0.
- ROW_REUSE_EN, first config:
  - tv=0 th=0: new_rows 4.
  - tv=1 th=0: new_rows 0 (rem_v 14).
  - tv=2 th=0: new_rows 1 (rem_v 1).
  - Every th>0: new_rows 0.
